// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register: accepts a WIDTH-bit word over a
// valid/ready handshake and drives it onto a serial line one bit per clock.
module piso_shift_register #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done,
  output logic             state_dbg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count, count_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [WIDTH-1:0] load_word;
  logic             last_bit;
  logic             accept;

  // Handshake: a word transfers on any rising edge where load_valid and
  // load_ready are both high. load_ready is a function of state only, so the
  // source may hold load_valid high for as long as it likes; parallel_in is
  // sampled only on the transferring edge and must be stable there.
  assign last_bit   = (state == SHIFT) && (count == LAST);
  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  // The register always shifts toward its MSB, so LSB-first order is obtained
  // by loading the word bit-reversed.
  always_comb begin
    load_word = parallel_in;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        load_word[i] = parallel_in[WIDTH-1-i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    shreg_next = shreg;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SHIFT;
          count_next = '0;
          shreg_next = load_word;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          count_next = count + CW'(1);
          shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end else if (accept) begin
          count_next = '0;
          shreg_next = load_word;
        end else begin
          state_next = IDLE;
          count_next = '0;
          shreg_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
        shreg_next = '0;
      end
    endcase
  end

  // Every output below is decoded from flops only; no input reaches them.
  assign serial_valid = (state == SHIFT);
  assign busy         = (state == SHIFT);
  assign done         = last_bit;
  assign serial_out   = shreg[WIDTH-1] & serial_valid;
  assign state_dbg    = state;

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register, MSB-first and LSB-first instances
// driven from the same stimulus.
module tb_piso_shift_register;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] parallel_in = 4'b0000;
  logic       load_valid = 1'b0;

  logic load_ready, serial_out, serial_valid, busy, done, state_dbg;
  logic l_load_ready, l_serial_out, l_serial_valid, l_busy, l_done, l_state_dbg;

  int checks = 0;
  int passes = 0;

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out), .serial_valid(serial_valid),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .parallel_in(parallel_in), .load_valid(load_valid),
    .load_ready(l_load_ready), .serial_out(l_serial_out), .serial_valid(l_serial_valid),
    .busy(l_busy), .done(l_done), .state_dbg(l_state_dbg)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed vector order: {serial_out, serial_valid, busy, done, load_ready}
  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if ({serial_out, serial_valid, busy, done} !== 4'b0000)
      $display("FAIL reset_held got %b exp 0000", {serial_out, serial_valid, busy, done});
    else passes++;
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001)
      $display("FAIL reset_release got %b exp 00001",
               {serial_out, serial_valid, busy, done, load_ready});
    else passes++;
  endtask

  task automatic test_single_word();
    logic [3:0] w = 4'b1010;
    logic [4:0] exp_v;
    parallel_in = w;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
    parallel_in = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      exp_v = {w[3-i], 1'b1, 1'b1, (i == 3), (i == 3)};
      checks++;
      if ({serial_out, serial_valid, busy, done, load_ready} !== exp_v)
        $display("FAIL single_bit%0d got %b exp %b", i,
                 {serial_out, serial_valid, busy, done, load_ready}, exp_v);
      else passes++;
      step();
    end
    checks++;
    if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001)
      $display("FAIL single_idle got %b exp 00001",
               {serial_out, serial_valid, busy, done, load_ready});
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits = 8'b1010_0110;
    logic [4:0] exp_v;
    parallel_in = 4'b1010;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        parallel_in = 4'b0110;
        load_valid  = 1'b1;
      end
      exp_v = {bits[7-i], 1'b1, 1'b1, (i == 3 || i == 7), (i == 3 || i == 7)};
      checks++;
      if ({serial_out, serial_valid, busy, done, load_ready} !== exp_v)
        $display("FAIL b2b_bit%0d got %b exp %b", i,
                 {serial_out, serial_valid, busy, done, load_ready}, exp_v);
      else passes++;
      step();
      if (i == 3) load_valid = 1'b0;
    end
    checks++;
    if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001)
      $display("FAIL b2b_idle got %b exp 00001",
               {serial_out, serial_valid, busy, done, load_ready});
    else passes++;
  endtask

  task automatic test_load_ignored_mid_word();
    logic [7:0] bits = 8'b0000_1111;
    logic [4:0] exp_v;
    parallel_in = 4'b0000;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) begin
        parallel_in = 4'b1111;
        load_valid  = 1'b1;
      end
      exp_v = {bits[7-i], 1'b1, 1'b1, (i == 3 || i == 7), (i == 3 || i == 7)};
      checks++;
      if ({serial_out, serial_valid, busy, done, load_ready} !== exp_v)
        $display("FAIL hold_bit%0d got %b exp %b", i,
                 {serial_out, serial_valid, busy, done, load_ready}, exp_v);
      else passes++;
      step();
      if (i == 3) load_valid = 1'b0;
    end
    checks++;
    if ({serial_out, serial_valid, busy, done} !== 4'b0000)
      $display("FAIL hold_idle got %b exp 0000", {serial_out, serial_valid, busy, done});
    else passes++;
  endtask

  task automatic test_reset_mid_word();
    logic [3:0] w2 = 4'b0011;
    logic [4:0] exp_v;
    parallel_in = 4'b1100;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
    checks++;
    if ({serial_out, serial_valid} !== 2'b11)
      $display("FAIL rst_mid_bit0 got %b exp 11", {serial_out, serial_valid});
    else passes++;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({serial_out, serial_valid, busy, done, load_ready} !== 5'b00001)
        $display("FAIL rst_mid_after%0d got %b exp 00001", i,
                 {serial_out, serial_valid, busy, done, load_ready});
      else passes++;
      step();
    end
    parallel_in = w2;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_v = {w2[3-i], 1'b1, 1'b1, (i == 3), (i == 3)};
      checks++;
      if ({serial_out, serial_valid, busy, done, load_ready} !== exp_v)
        $display("FAIL rst_reload_bit%0d got %b exp %b", i,
                 {serial_out, serial_valid, busy, done, load_ready}, exp_v);
      else passes++;
      step();
    end
  endtask

  task automatic test_loopback_and_order();
    logic [3:0] w = 4'b1010;
    logic [3:0] lsb_seq = 4'b0101;
    logic [3:0] sipo = 4'b0000;
    parallel_in = w;
    load_valid  = 1'b1;
    step();
    load_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (serial_valid) sipo = {sipo[2:0], serial_out};
      checks++;
      if ({l_serial_out, l_serial_valid} !== {lsb_seq[3-i], 1'b1})
        $display("FAIL lsb_bit%0d got %b exp %b", i,
                 {l_serial_out, l_serial_valid}, {lsb_seq[3-i], 1'b1});
      else passes++;
      step();
    end
    checks++;
    if (sipo !== w)
      $display("FAIL sipo_rebuild got %b exp %b", sipo, w);
    else passes++;
    checks++;
    if ({l_serial_valid, l_busy, l_serial_out} !== 3'b000)
      $display("FAIL lsb_idle got %b exp 000", {l_serial_valid, l_busy, l_serial_out});
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_load_ignored_mid_word();
    test_reset_mid_word();
    test_loopback_and_order();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
